nn_resource_arbiter: RTL and testbench
======================================

Name: nn_resource_arbiter

Overview:
- Round-robin arbiter that shares the single RAM port set and the single fixed-point multiplier between REQS neural-network layer controllers.
- Replaces wired-OR bus merging with an explicit req/gnt handshake and a registered owner.
- Holds each grant while the owner keeps requesting.
- Inserts a RAM_DELAY-cycle drain before handover, so in-flight read data is consumed by the correct layer.

Parameters:
- REQS, 3, number of requesting layers (2..8)
- ADDR_W, 8, RAM address width
- NUM_W, 17, data/multiplier operand width
- RAM_DELAY, 1, RAM read latency in cycles (1..4); also the drain length
- IDX_W, $clog2(REQS), owner index width (derived)

Ports:
- clk  in  1  clock
- nreset  in  1  asynchronous active-low reset
- enable  in  1  global advance enable
- req  in  REQS  per-layer access request
- gnt  out  REQS  one-hot grant, registered
- req_ram_write  in  REQS  per-layer write strobe
- req_ram_addr_write  in  REQS*ADDR_W  per-layer write address, packed, layer k at [k*ADDR_W +: ADDR_W]
- req_ram_data_write  in  REQS*NUM_W  per-layer write data, packed
- req_ram_addr_read  in  REQS*ADDR_W  per-layer read address, packed
- req_mult_v1  in  REQS*NUM_W  per-layer multiplier operand 1
- req_mult_v2  in  REQS*NUM_W  per-layer multiplier operand 2
- ram_write  out  1  to RAM
- ram_addr_write  out  ADDR_W  to RAM
- ram_data_write  out  NUM_W  to RAM
- ram_addr_read  out  ADDR_W  to RAM
- mult_v1  out  NUM_W  to multiplier
- mult_v2  out  NUM_W  to multiplier
- owner  out  IDX_W  index of current or last owner
- busy  out  1  high in GRANT or DRAIN

Behaviour:
- Reset (async, nreset low): state=IDLE, gnt=0, owner=0, rr pointer=0, drain counter=0, busy=0. All bus outputs read 0 because no grant is active. Reset mid-transfer aborts immediately, with no drain.

FSM states: IDLE, GRANT, DRAIN. All transitions require enable=1; enable=0 freezes state, gnt, pointer and counter.
- IDLE -> GRANT when any req bit is set.
  - Winner is the first set bit scanning from the pointer upward, wrapping modulo REQS.
  - gnt[winner] and owner are registered on this edge. gnt is therefore visible 1 cycle after req is first sampled.
- GRANT -> DRAIN when req[owner]=0 on a clock edge. gnt drops on that edge, the counter loads RAM_DELAY, and the pointer is set to (owner+1) mod REQS.
- DRAIN: counter decrements each enabled cycle. At 1 -> IDLE. Arbitration happens in IDLE, so the next grant appears RAM_DELAY+1 cycles after the release edge.
- Grant is never preempted. Other requesters wait indefinitely while the owner holds req.

Bus muxing (combinational from registered owner/gnt):
- In GRANT: all RAM and multiplier outputs equal the owner's slice.
- ram_write = req_ram_write[owner] & req[owner] & gnt[owner]. A write is suppressed in the same cycle the owner drops req.
- Non-owner strobes and data are ignored entirely.
- In IDLE and DRAIN: ram_write=0. ram_addr_read keeps the last owner's address so a pending read completes. All other outputs are 0.

Boundary cases:
- Simultaneous requests: round-robin order from the pointer; ties are impossible.
- Single requester: re-granted after the drain regardless of the pointer.
- Pointer wrap: REQS-1 -> 0.
- req asserted and dropped before being sampled: no grant.
- gnt is always one-hot or zero; a violation is an assertion failure.

Test Plan:
- Reset then req=3'b001: gnt=001 one cycle later, owner=0, busy=1. Writes with addr 8'h10, data 17'h00180 appear on the RAM outputs. Dropping req gives gnt=000, then 1 drain cycle, then IDLE.
- req=3'b111 held continuously, each owner releasing after 4 cycles: grant order 0,1,2,0. Gaps between grants are exactly RAM_DELAY+1 = 2 cycles.
- Owner 1 granted while layer 2 drives ram_write=1, addr 8'hFF: RAM sees no write to 8'hFF, and mult_v1/v2 equal layer 1 operands (17'h00100, 17'h00080).
- Owner drops req in the same cycle it asserts req_ram_write: ram_write=0 that cycle.
- RAM_DELAY=3: the read address of the old owner stays on ram_addr_read for 3 drain cycles, and the next gnt occurs 4 cycles after release.
- nreset pulsed low mid-GRANT with enable=1: gnt=0, busy=0, ram_write=0 immediately. After reset release with req=3'b110, the first grant goes to layer 1.

Source files
------------

// File: rtl/nn_resource_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : nn_resource_arbiter_if
// Description : Bundle between the neural-network layer controllers and the
//               shared RAM / multiplier arbiter.
//               master : layer-controller side (drives req and per-layer buses)
//               slave  : arbiter side (drives gnt, muxed RAM/mult buses,
//                        owner, busy)
//               Ports carried:
//                 enable              global advance enable
//                 req / gnt           per-layer request / one-hot grant
//                 req_ram_*           packed per-layer RAM strobes/addr/data
//                 req_mult_v1/v2      packed per-layer multiplier operands
//                 ram_*, mult_v1/v2   shared RAM / multiplier side
//                 owner, busy         arbitration status
// Revision    : 1.0 - initial release
// ============================================================================
interface nn_resource_arbiter_if #(
    parameter int REQS   = 3,
    parameter int ADDR_W = 8,
    parameter int NUM_W  = 17,
    parameter int IDX_W  = $clog2(REQS)
);
    logic                     enable;
    logic [REQS-1:0]          req;
    logic [REQS-1:0]          gnt;
    logic [REQS-1:0]          req_ram_write;
    logic [REQS*ADDR_W-1:0]   req_ram_addr_write;
    logic [REQS*NUM_W-1:0]    req_ram_data_write;
    logic [REQS*ADDR_W-1:0]   req_ram_addr_read;
    logic [REQS*NUM_W-1:0]    req_mult_v1;
    logic [REQS*NUM_W-1:0]    req_mult_v2;
    logic                     ram_write;
    logic [ADDR_W-1:0]        ram_addr_write;
    logic [NUM_W-1:0]         ram_data_write;
    logic [ADDR_W-1:0]        ram_addr_read;
    logic [NUM_W-1:0]         mult_v1;
    logic [NUM_W-1:0]         mult_v2;
    logic [IDX_W-1:0]         owner;
    logic                     busy;

    modport master (
        output enable, req, req_ram_write, req_ram_addr_write,
               req_ram_data_write, req_ram_addr_read, req_mult_v1, req_mult_v2,
        input  gnt, ram_write, ram_addr_write, ram_data_write, ram_addr_read,
               mult_v1, mult_v2, owner, busy
    );

    modport slave (
        input  enable, req, req_ram_write, req_ram_addr_write,
               req_ram_data_write, req_ram_addr_read, req_mult_v1, req_mult_v2,
        output gnt, ram_write, ram_addr_write, ram_data_write, ram_addr_read,
               mult_v1, mult_v2, owner, busy
    );
endinterface
`default_nettype wire

// File: rtl/nn_resource_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : nn_resource_arbiter
// Description : Round-robin arbiter sharing one RAM port set and one
//               fixed-point multiplier between REQS layer controllers.
//               A grant is held while its owner keeps requesting; on release
//               a RAM_DELAY-cycle drain runs before the next arbitration so
//               in-flight read data reaches the right layer.
//               Ports:
//                 clk    : clock
//                 nreset : asynchronous active-low reset
//                 bus    : nn_resource_arbiter_if.slave (req/gnt handshake,
//                          per-layer buses in, shared RAM/mult buses out,
//                          owner index and busy status)
// Revision    : 1.0 - initial release
// ============================================================================
module nn_resource_arbiter #(
    parameter int REQS      = 3,
    parameter int ADDR_W    = 8,
    parameter int NUM_W     = 17,
    parameter int RAM_DELAY = 1,
    parameter int IDX_W     = $clog2(REQS)
) (
    input  wire logic            clk,
    input  wire logic            nreset,
    nn_resource_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam int              CNT_W      = 3;
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(RAM_DELAY);
    localparam logic [REQS-1:0]  ONE_HOT0   = {{(REQS-1){1'b0}}, 1'b1};

    state_t             state_q, state_d;
    logic [REQS-1:0]    gnt_q, gnt_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  rd_addr_q;

    logic               found;
    logic [IDX_W-1:0]   winner;
    logic [IDX_W-1:0]   owner_inc;
    int                 scan_idx;
    logic               in_grant;

    logic [ADDR_W-1:0]  own_aw, own_ar;
    logic [NUM_W-1:0]   own_dw, own_m1, own_m2;

    // First requester at or above the pointer, wrapping modulo REQS.
    always_comb begin
        winner   = ptr_q;
        found    = 1'b0;
        scan_idx = 0;
        for (int i = 0; i < REQS; i++) begin
            scan_idx = (int'(ptr_q) + i) % REQS;
            if (!found && bus.req[scan_idx]) begin
                found  = 1'b1;
                winner = IDX_W'(scan_idx);
            end
        end
    end

    assign owner_inc = (owner_q == IDX_W'(REQS - 1)) ? '0 : owner_q + IDX_W'(1);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        if (bus.enable) begin
            case (state_q)
                S_IDLE: begin
                    if (found) begin
                        state_d = S_GRANT;
                        gnt_d   = ONE_HOT0 << winner;
                        owner_d = winner;
                    end
                end
                S_GRANT: begin
                    if (!bus.req[owner_q]) begin
                        state_d = S_DRAIN;
                        gnt_d   = '0;
                        cnt_d   = DRAIN_LOAD;
                        ptr_d   = owner_inc;
                    end
                end
                S_DRAIN: begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    gnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Owner's slices of the packed per-layer buses.
    assign own_aw = bus.req_ram_addr_write[int'(owner_q)*ADDR_W +: ADDR_W];
    assign own_ar = bus.req_ram_addr_read [int'(owner_q)*ADDR_W +: ADDR_W];
    assign own_dw = bus.req_ram_data_write[int'(owner_q)*NUM_W  +: NUM_W];
    assign own_m1 = bus.req_mult_v1       [int'(owner_q)*NUM_W  +: NUM_W];
    assign own_m2 = bus.req_mult_v2       [int'(owner_q)*NUM_W  +: NUM_W];

    // Last read address seen during GRANT; held through DRAIN/IDLE so the
    // pending read is not disturbed by the arbitration gap.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            rd_addr_q <= '0;
        end else if (state_q == S_GRANT) begin
            rd_addr_q <= own_ar;
        end
    end

    assign in_grant = (state_q == S_GRANT);

    assign bus.gnt            = gnt_q;
    assign bus.owner          = owner_q;
    assign bus.busy           = (state_q != S_IDLE);
    // Gating with req[owner] suppresses a write issued on the release cycle.
    assign bus.ram_write      = in_grant & bus.req_ram_write[owner_q]
                                & bus.req[owner_q] & gnt_q[owner_q];
    assign bus.ram_addr_write = in_grant ? own_aw : '0;
    assign bus.ram_data_write = in_grant ? own_dw : '0;
    assign bus.ram_addr_read  = in_grant ? own_ar : rd_addr_q;
    assign bus.mult_v1        = in_grant ? own_m1 : '0;
    assign bus.mult_v2        = in_grant ? own_m2 : '0;

    a_gnt_onehot0: assert property (@(posedge clk) disable iff (!nreset) $onehot0(gnt_q));

endmodule
`default_nettype wire

// File: tb/tb_nn_resource_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_nn_resource_arbiter
// Description : Self-checking bench for nn_resource_arbiter. One instance with
//               RAM_DELAY=1 runs a cycle-by-cycle vector table plus reset and
//               round-robin sequences; a second instance with RAM_DELAY=3
//               exercises the longer drain.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nn_resource_arbiter;
    logic clk = 1'b0;
    logic nreset = 1'b0;
    always #5 clk = ~clk;

    nn_resource_arbiter_if #(.REQS(3), .ADDR_W(8), .NUM_W(17)) b1 ();
    nn_resource_arbiter_if #(.REQS(3), .ADDR_W(8), .NUM_W(17)) b2 ();

    nn_resource_arbiter #(.REQS(3), .ADDR_W(8), .NUM_W(17), .RAM_DELAY(1)) u_dut1 (
        .clk(clk), .nreset(nreset), .bus(b1));
    nn_resource_arbiter #(.REQS(3), .ADDR_W(8), .NUM_W(17), .RAM_DELAY(3)) u_dut3 (
        .clk(clk), .nreset(nreset), .bus(b2));

    // Per-layer bus values, shared by both instances.
    logic [7:0]  L_AW [3] = '{8'h10, 8'h11, 8'hFF};
    logic [16:0] L_DW [3] = '{17'h00180, 17'h00181, 17'h1FFFF};
    logic [7:0]  L_AR [3] = '{8'h20, 8'h21, 8'h22};
    logic [16:0] L_M1 [3] = '{17'h00011, 17'h00100, 17'h00031};
    logic [16:0] L_M2 [3] = '{17'h00012, 17'h00080, 17'h00032};

    assign b1.req_ram_addr_write = {L_AW[2], L_AW[1], L_AW[0]};
    assign b1.req_ram_data_write = {L_DW[2], L_DW[1], L_DW[0]};
    assign b1.req_ram_addr_read  = {L_AR[2], L_AR[1], L_AR[0]};
    assign b1.req_mult_v1        = {L_M1[2], L_M1[1], L_M1[0]};
    assign b1.req_mult_v2        = {L_M2[2], L_M2[1], L_M2[0]};
    assign b2.req_ram_addr_write = {L_AW[2], L_AW[1], L_AW[0]};
    assign b2.req_ram_data_write = {L_DW[2], L_DW[1], L_DW[0]};
    assign b2.req_ram_addr_read  = {L_AR[2], L_AR[1], L_AR[0]};
    assign b2.req_mult_v1        = {L_M1[2], L_M1[1], L_M1[0]};
    assign b2.req_mult_v2        = {L_M2[2], L_M2[1], L_M2[0]};

    typedef struct {
        logic       en;
        logic [2:0] req;
        logic [2:0] wr;
        logic [2:0] e_gnt;
        logic [1:0] e_own;
        logic       e_busy;
        logic       e_rw;
        logic [1:0] e_sel;   // layer whose buses are expected on the outputs, 3 = none
        logic [7:0] e_ar;
    } vec_t;

    localparam int NV = 31;
    vec_t vecs [NV];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Counts negedges with gnt==0 until a grant is seen; -1 on timeout.
    task automatic wait_grant(input int which, output int zeros);
        logic [2:0] g;
        zeros = -1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            #1;
            g = (which == 1) ? b1.gnt : b2.gnt;
            if (g != 3'b000) begin
                zeros = t;
                return;
            end
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        int zeros;
        logic [1:0] order [4];
        logic [2:0] held;
        logic [16:0] e_dw, e_m1, e_m2;
        logic [7:0]  e_aw;

        // en, req, wr, gnt, own, busy, rw, sel, ar
        vecs[0]  = '{1'b1, 3'b000, 3'b000, 3'b000, 2'd0, 1'b0, 1'b0, 2'd3, 8'h00};
        vecs[1]  = '{1'b1, 3'b001, 3'b001, 3'b000, 2'd0, 1'b0, 1'b0, 2'd3, 8'h00};
        vecs[2]  = '{1'b1, 3'b001, 3'b001, 3'b001, 2'd0, 1'b1, 1'b1, 2'd0, 8'h20};
        vecs[3]  = '{1'b1, 3'b001, 3'b000, 3'b001, 2'd0, 1'b1, 1'b0, 2'd0, 8'h20};
        vecs[4]  = '{1'b1, 3'b000, 3'b001, 3'b001, 2'd0, 1'b1, 1'b0, 2'd0, 8'h20};
        vecs[5]  = '{1'b1, 3'b000, 3'b000, 3'b000, 2'd0, 1'b1, 1'b0, 2'd3, 8'h20};
        vecs[6]  = '{1'b1, 3'b000, 3'b000, 3'b000, 2'd0, 1'b0, 1'b0, 2'd3, 8'h20};
        vecs[7]  = '{1'b1, 3'b111, 3'b000, 3'b000, 2'd0, 1'b0, 1'b0, 2'd3, 8'h20};
        vecs[8]  = '{1'b1, 3'b111, 3'b100, 3'b010, 2'd1, 1'b1, 1'b0, 2'd1, 8'h21};
        vecs[9]  = '{1'b1, 3'b111, 3'b110, 3'b010, 2'd1, 1'b1, 1'b1, 2'd1, 8'h21};
        vecs[10] = '{1'b1, 3'b101, 3'b000, 3'b010, 2'd1, 1'b1, 1'b0, 2'd1, 8'h21};
        vecs[11] = '{1'b1, 3'b111, 3'b000, 3'b000, 2'd1, 1'b1, 1'b0, 2'd3, 8'h21};
        vecs[12] = '{1'b1, 3'b111, 3'b000, 3'b000, 2'd1, 1'b0, 1'b0, 2'd3, 8'h21};
        vecs[13] = '{1'b1, 3'b111, 3'b000, 3'b100, 2'd2, 1'b1, 1'b0, 2'd2, 8'h22};
        vecs[14] = '{1'b1, 3'b011, 3'b000, 3'b100, 2'd2, 1'b1, 1'b0, 2'd2, 8'h22};
        vecs[15] = '{1'b1, 3'b011, 3'b000, 3'b000, 2'd2, 1'b1, 1'b0, 2'd3, 8'h22};
        vecs[16] = '{1'b1, 3'b011, 3'b000, 3'b000, 2'd2, 1'b0, 1'b0, 2'd3, 8'h22};
        vecs[17] = '{1'b1, 3'b011, 3'b000, 3'b001, 2'd0, 1'b1, 1'b0, 2'd0, 8'h20};
        vecs[18] = '{1'b1, 3'b010, 3'b000, 3'b001, 2'd0, 1'b1, 1'b0, 2'd0, 8'h20};
        vecs[19] = '{1'b1, 3'b010, 3'b000, 3'b000, 2'd0, 1'b1, 1'b0, 2'd3, 8'h20};
        vecs[20] = '{1'b1, 3'b000, 3'b000, 3'b000, 2'd0, 1'b0, 1'b0, 2'd3, 8'h20};
        vecs[21] = '{1'b1, 3'b000, 3'b000, 3'b000, 2'd0, 1'b0, 1'b0, 2'd3, 8'h20};
        vecs[22] = '{1'b0, 3'b100, 3'b000, 3'b000, 2'd0, 1'b0, 1'b0, 2'd3, 8'h20};
        vecs[23] = '{1'b0, 3'b100, 3'b000, 3'b000, 2'd0, 1'b0, 1'b0, 2'd3, 8'h20};
        vecs[24] = '{1'b1, 3'b100, 3'b000, 3'b000, 2'd0, 1'b0, 1'b0, 2'd3, 8'h20};
        vecs[25] = '{1'b1, 3'b100, 3'b000, 3'b100, 2'd2, 1'b1, 1'b0, 2'd2, 8'h22};
        vecs[26] = '{1'b0, 3'b000, 3'b000, 3'b100, 2'd2, 1'b1, 1'b0, 2'd2, 8'h22};
        vecs[27] = '{1'b0, 3'b000, 3'b000, 3'b100, 2'd2, 1'b1, 1'b0, 2'd2, 8'h22};
        vecs[28] = '{1'b1, 3'b000, 3'b000, 3'b100, 2'd2, 1'b1, 1'b0, 2'd2, 8'h22};
        vecs[29] = '{1'b1, 3'b000, 3'b000, 3'b000, 2'd2, 1'b1, 1'b0, 2'd3, 8'h22};
        vecs[30] = '{1'b1, 3'b000, 3'b000, 3'b000, 2'd2, 1'b0, 1'b0, 2'd3, 8'h22};

        // Reset state, with every layer requesting and writing.
        b1.enable = 1'b1; b1.req = 3'b111; b1.req_ram_write = 3'b111;
        b2.enable = 1'b1; b2.req = 3'b000; b2.req_ram_write = 3'b000;
        repeat (2) @(negedge clk);
        #1;
        chk("reset gnt",       32'(b1.gnt),            32'h0);
        chk("reset busy",      32'(b1.busy),           32'h0);
        chk("reset owner",     32'(b1.owner),          32'h0);
        chk("reset ram_write", 32'(b1.ram_write),      32'h0);
        chk("reset addr_wr",   32'(b1.ram_addr_write), 32'h0);
        chk("reset addr_rd",   32'(b1.ram_addr_read),  32'h0);
        chk("reset mult_v1",   32'(b1.mult_v1),        32'h0);
        b1.req = 3'b000; b1.req_ram_write = 3'b000;
        nreset = 1'b1;

        // Cycle-by-cycle table.
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            b1.enable        = vecs[i].en;
            b1.req           = vecs[i].req;
            b1.req_ram_write = vecs[i].wr;
            #1;
            if (vecs[i].e_sel == 2'd3) begin
                e_aw = '0; e_dw = '0; e_m1 = '0; e_m2 = '0;
            end else begin
                e_aw = L_AW[vecs[i].e_sel]; e_dw = L_DW[vecs[i].e_sel];
                e_m1 = L_M1[vecs[i].e_sel]; e_m2 = L_M2[vecs[i].e_sel];
            end
            chk($sformatf("row%0d gnt", i),       32'(b1.gnt),            32'(vecs[i].e_gnt));
            chk($sformatf("row%0d owner", i),     32'(b1.owner),          32'(vecs[i].e_own));
            chk($sformatf("row%0d busy", i),      32'(b1.busy),           32'(vecs[i].e_busy));
            chk($sformatf("row%0d ram_write", i), 32'(b1.ram_write),      32'(vecs[i].e_rw));
            chk($sformatf("row%0d addr_wr", i),   32'(b1.ram_addr_write), 32'(e_aw));
            chk($sformatf("row%0d data_wr", i),   32'(b1.ram_data_write), 32'(e_dw));
            chk($sformatf("row%0d mult_v1", i),   32'(b1.mult_v1),        32'(e_m1));
            chk($sformatf("row%0d mult_v2", i),   32'(b1.mult_v2),        32'(e_m2));
            chk($sformatf("row%0d addr_rd", i),   32'(b1.ram_addr_read),  32'(vecs[i].e_ar));
        end

        // Reset pulsed mid-GRANT aborts at once; next arbitration restarts at 0.
        @(negedge clk);
        b1.enable = 1'b1; b1.req = 3'b001; b1.req_ram_write = 3'b001;
        @(negedge clk);
        #1;
        chk("pre-reset gnt", 32'(b1.gnt), 32'h1);
        #2;
        nreset = 1'b0;
        #1;
        chk("mid reset gnt",       32'(b1.gnt),       32'h0);
        chk("mid reset busy",      32'(b1.busy),      32'h0);
        chk("mid reset ram_write", 32'(b1.ram_write), 32'h0);
        @(negedge clk);
        b1.req = 3'b110; b1.req_ram_write = 3'b000;
        nreset = 1'b1;
        @(negedge clk);
        #1;
        chk("post reset gnt",   32'(b1.gnt),   32'h2);
        chk("post reset owner", 32'(b1.owner), 32'h1);
        b1.req = 3'b000;
        repeat (3) @(negedge clk);

        // Round robin with all layers requesting; each owner holds 4 cycles.
        nreset = 1'b0;
        @(negedge clk);
        nreset = 1'b1;
        @(negedge clk);
        order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd2; order[3] = 2'd0;
        b1.req = 3'b111;
        wait_grant(1, zeros);
        chk("rr first latency", 32'(zeros),    32'd0);
        chk("rr owner 0",       32'(b1.owner), 32'(order[0]));
        for (int k = 1; k < 4; k++) begin
            held = b1.gnt;
            for (int h = 0; h < 3; h++) begin
                @(negedge clk);
                #1;
                chk($sformatf("rr hold%0d.%0d", k, h), 32'(b1.gnt), 32'(held));
            end
            b1.req = 3'b111 & ~held;
            wait_grant(1, zeros);
            chk($sformatf("rr gap %0d", k),   32'(zeros),    32'd2);
            chk($sformatf("rr owner %0d", k), 32'(b1.owner), 32'(order[k]));
            b1.req = 3'b111;
        end
        b1.req = 3'b000;

        // RAM_DELAY=3: read address held through 3 drain cycles, regrant 4 cycles after release.
        @(negedge clk);
        b2.req = 3'b001;
        wait_grant(2, zeros);
        chk("d3 first latency", 32'(zeros),  32'd0);
        chk("d3 gnt",           32'(b2.gnt), 32'h1);
        @(negedge clk);
        b2.req = 3'b000;
        for (int d = 1; d <= 4; d++) begin
            @(negedge clk);
            #1;
            chk($sformatf("d3 drain%0d addr_rd", d), 32'(b2.ram_addr_read), 32'h20);
            chk($sformatf("d3 drain%0d gnt", d),     32'(b2.gnt),           32'h0);
            chk($sformatf("d3 drain%0d busy", d),    32'(b2.busy),          (d <= 3) ? 32'h1 : 32'h0);
            if (d == 1) b2.req = 3'b001;
        end
        @(negedge clk);
        #1;
        chk("d3 regrant gnt",   32'(b2.gnt),   32'h1);
        chk("d3 regrant owner", 32'(b2.owner), 32'h0);
        b2.req = 3'b000;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
